// File: rtl/us_sched_pkg.sv
// Shared definitions for the microsecond event scheduler.
// Provides default geometry, output FSM state encodings and the tick
// rising-edge detect helper used by the scheduler top level.
// Optional feature macro used by this block: SCHED_ONESHOT_EN.
package us_sched_pkg;

  localparam int unsigned NCH_DEF = 4;
  localparam int unsigned PW_DEF  = 16;
  localparam int unsigned CW_DEF  = 2;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_OFFER = 1'b1
  } state_e;

  // One count per tick pulse: a tick is recognised only on its first high clk.
  function automatic logic tick_rise(input logic cur, input logic prev);
    return cur & ~prev;
  endfunction

endpackage

// File: rtl/us_sched_chan.sv
// One microsecond timer channel of the event scheduler.
// Holds the programmable period and the running counter, and reports an
// expiry when the last tick of the period is counted.
// Ports:
//   clk, rst       clock, asynchronous active-low reset
//   tick_rise      one-clk strobe per timebase tick
//   cfg_hit        configuration write addressed to this channel
//   cfg_period     period to load (0 disables the channel)
//   cfg_oneshot    one-shot mode select (used only with SCHED_ONESHOT_EN)
//   expire_c       combinational expiry strobe for this clk
// With SCHED_ONESHOT_EN defined, a one-shot channel clears its own period
// on expiry; otherwise cfg_oneshot is ignored and no state is kept for it.
module us_sched_chan
  import us_sched_pkg::*;
#(
  parameter int unsigned PW = PW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          tick_rise,
  input  logic          cfg_hit,
  input  logic [PW-1:0] cfg_period,
  input  logic          cfg_oneshot,
  output logic          expire_c
);

  logic [PW-1:0] period_q, period_d;
  logic [PW-1:0] cnt_q, cnt_d;
  logic          active;
  logic          at_end;

  assign active = (period_q != '0);
  assign at_end = (cnt_q == period_q - PW'(1));

  // A same-cycle config write wins over the expiry it would otherwise see.
  assign expire_c = tick_rise & active & at_end & ~cfg_hit;

`ifdef SCHED_ONESHOT_EN
  logic oneshot_q, oneshot_d;
`else
  logic unused_oneshot;
  assign unused_oneshot = cfg_oneshot;
`endif

  // Period/counter next state.
  always_comb begin
    period_d = period_q;
    cnt_d    = cnt_q;
`ifdef SCHED_ONESHOT_EN
    oneshot_d = oneshot_q;
`endif
    if (cfg_hit) begin
      period_d = cfg_period;
      cnt_d    = '0;
`ifdef SCHED_ONESHOT_EN
      oneshot_d = cfg_oneshot;
`endif
    end else if (tick_rise && active) begin
      cnt_d = at_end ? '0 : cnt_q + PW'(1);
`ifdef SCHED_ONESHOT_EN
      if (at_end && oneshot_q) begin
        period_d = '0;
      end
`endif
    end
  end

  // Channel state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      period_q <= '0;
      cnt_q    <= '0;
`ifdef SCHED_ONESHOT_EN
      oneshot_q <= 1'b0;
`endif
    end else begin
      period_q <= period_d;
      cnt_q    <= cnt_d;
`ifdef SCHED_ONESHOT_EN
      oneshot_q <= oneshot_d;
`endif
    end
  end

endmodule

// File: rtl/us_event_sched.sv
// Periodic microsecond event scheduler.
// NCH timer channels count rising edges of the 1 MHz tick; each expiry
// raises a pending flag, and pending channels are served round-robin on a
// single valid/ready event port. A re-expiry while still pending is merged
// and recorded in a sticky per-channel overrun flag.
// Ports:
//   clk, rst                  clock, asynchronous active-low reset
//   tick                      timebase tick (multi-cycle pulse, rising edge counts)
//   cfg_we/cfg_ch             configuration write strobe and target channel
//   cfg_period/cfg_oneshot    period (0 = disabled) and one-shot select
//   evt_valid/evt_ch          offered event and its channel
//   evt_ready                 consumer accepts the offered event
//   overrun                   sticky per-channel overrun flags
// Optional feature macro: SCHED_ONESHOT_EN (one-shot channels, see us_sched_chan).
// Geometry constraints: 2 <= NCH <= 8, 2**CW >= NCH.
module us_event_sched
  import us_sched_pkg::*;
#(
  parameter int unsigned NCH = NCH_DEF,
  parameter int unsigned PW  = PW_DEF,
  parameter int unsigned CW  = CW_DEF
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           tick,
  input  logic           cfg_we,
  input  logic [CW-1:0]  cfg_ch,
  input  logic [PW-1:0]  cfg_period,
  input  logic           cfg_oneshot,
  output logic           evt_valid,
  output logic [CW-1:0]  evt_ch,
  input  logic           evt_ready,
  output logic [NCH-1:0] overrun
);

  logic           tick_d_q;
  logic           tick_rise_c;
  logic [NCH-1:0] cfg_hit;
  logic [NCH-1:0] acc_hit;
  logic [NCH-1:0] expire;
  logic [NCH-1:0] pend_q, pend_d;
  logic [NCH-1:0] ovr_q, ovr_d;
  logic [CW-1:0]  rr_ptr_q;
  logic [CW-1:0]  evt_ch_q;
  logic           evt_valid_q;
  state_e         state_q;
  logic           accept;
  logic           hi_hit, lo_hit;
  logic [CW-1:0]  hi_ch, lo_ch, sel_ch;

  assign tick_rise_c = tick_rise(tick, tick_d_q);
  assign accept      = evt_valid_q & evt_ready;

  // Tick edge-detect register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) tick_d_q <= 1'b0;
    else      tick_d_q <= tick;
  end

  // Timer channels; cfg_ch values >= NCH decode to no channel.
  for (genvar i = 0; i < int'(NCH); i++) begin : g_chan
    assign cfg_hit[i] = cfg_we & (cfg_ch == CW'(i));
    assign acc_hit[i] = accept & (evt_ch_q == CW'(i));

    us_sched_chan #(.PW(PW)) u_chan (
      .clk         (clk),
      .rst         (rst),
      .tick_rise   (tick_rise_c),
      .cfg_hit     (cfg_hit[i]),
      .cfg_period  (cfg_period),
      .cfg_oneshot (cfg_oneshot),
      .expire_c    (expire[i])
    );
  end

  // Pending/overrun update: config clear beats expiry, expiry beats accept.
  always_comb begin
    pend_d = pend_q;
    ovr_d  = ovr_q;
    for (int i = 0; i < int'(NCH); i++) begin
      if (cfg_hit[i]) begin
        pend_d[i] = 1'b0;
        ovr_d[i]  = 1'b0;
      end else if (expire[i]) begin
        pend_d[i] = 1'b1;
        if (pend_q[i] && !acc_hit[i]) ovr_d[i] = 1'b1;
      end else if (acc_hit[i]) begin
        pend_d[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_q <= '0;
      ovr_q  <= '0;
    end else begin
      pend_q <= pend_d;
      ovr_q  <= ovr_d;
    end
  end

  // Round-robin pick: first pending at or above rr_ptr, else first from 0.
  always_comb begin
    hi_hit = 1'b0;
    hi_ch  = '0;
    lo_hit = 1'b0;
    lo_ch  = '0;
    for (int j = 0; j < int'(NCH); j++) begin
      if (!hi_hit && pend_q[j] && (CW'(j) >= rr_ptr_q)) begin
        hi_hit = 1'b1;
        hi_ch  = CW'(j);
      end
      if (!lo_hit && pend_q[j]) begin
        lo_hit = 1'b1;
        lo_ch  = CW'(j);
      end
    end
    sel_ch = hi_hit ? hi_ch : lo_ch;
  end

  // Output FSM: offer is held stable until accepted, then one idle clk.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      evt_valid_q <= 1'b0;
      evt_ch_q    <= '0;
      rr_ptr_q    <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (|pend_q) begin
            evt_ch_q    <= sel_ch;
            evt_valid_q <= 1'b1;
            state_q     <= S_OFFER;
          end
        end
        S_OFFER: begin
          if (evt_ready) begin
            evt_valid_q <= 1'b0;
            rr_ptr_q    <= (evt_ch_q == CW'(NCH - 1)) ? '0 : evt_ch_q + CW'(1);
            state_q     <= S_IDLE;
          end
        end
        default: begin
          evt_valid_q <= 1'b0;
          state_q     <= S_IDLE;
        end
      endcase
    end
  end

  assign evt_valid = evt_valid_q;
  assign evt_ch    = evt_ch_q;
  assign overrun   = ovr_q;

endmodule

// File: tb/tb_us_event_sched.sv
// Directed bench for us_event_sched (NCH=4, PW=16, CW=2).
// Ticks are 5-clk high pulses every 50 clk; accepted events are logged by a
// monitor and compared against hand-computed expectations.
`timescale 1ns/1ps
module tb_us_event_sched;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        tick = 1'b0;
  logic        cfg_we = 1'b0;
  logic [1:0]  cfg_ch = 2'd0;
  logic [15:0] cfg_period = 16'd0;
  logic        cfg_oneshot = 1'b0;
  logic        evt_valid;
  logic [1:0]  evt_ch;
  logic        evt_ready = 1'b0;
  logic [3:0]  overrun;

  int passed = 0;
  int total  = 0;
  int cyc    = 0;
  logic [1:0] evq[$];
  int         evcyc[$];

  us_event_sched #(.NCH(4), .PW(16), .CW(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .tick        (tick),
    .cfg_we      (cfg_we),
    .cfg_ch      (cfg_ch),
    .cfg_period  (cfg_period),
    .cfg_oneshot (cfg_oneshot),
    .evt_valid   (evt_valid),
    .evt_ch      (evt_ch),
    .evt_ready   (evt_ready),
    .overrun     (overrun)
  );

  always #10 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (rst && evt_valid && evt_ready) begin
      evq.push_back(evt_ch);
      evcyc.push_back(cyc);
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic tick_pulse();
    tick = 1'b1;
    step(5);
    tick = 1'b0;
    step(45);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    step(2);
    rst = 1'b1;
    step(1);
    evq.delete();
    evcyc.delete();
  endtask

  task automatic cfg(input logic [1:0] ch, input logic [15:0] p, input logic os);
    cfg_we      = 1'b1;
    cfg_ch      = ch;
    cfg_period  = p;
    cfg_oneshot = os;
    step(1);
    cfg_we      = 1'b0;
    cfg_oneshot = 1'b0;
  endtask

  initial begin
    logic ok;

    // Reset state
    step(3);
    chk("rst_valid", 32'(evt_valid), 32'd0);
    chk("rst_ch", 32'(evt_ch), 32'd0);
    chk("rst_ovr", 32'(overrun), 32'd0);
    rst = 1'b1;
    step(1);

    // Channel 0 period 3, consumer always ready
    cfg(2'd0, 16'd3, 1'b0);
    evt_ready = 1'b1;
    tick_pulse();
    tick_pulse();
    chk("t1_none_after2", 32'(evq.size()), 32'd0);
    tick = 1'b1;
    step(1);
    chk("t1_lat_e0", 32'(evt_valid), 32'd0);
    step(1);
    chk("t1_lat_e1", 32'(evt_valid), 32'd1);
    chk("t1_lat_ch", 32'(evt_ch), 32'd0);
    step(1);
    chk("t1_one_clk", 32'(evt_valid), 32'd0);
    step(2);
    tick = 1'b0;
    step(45);
    repeat (3) tick_pulse();
    chk("t1_count6", 32'(evq.size()), 32'd2);
    ok = (evq.size() == 2) && (evq[0] == 2'd0) && (evq[1] == 2'd0);
    chk("t1_chan", 32'(ok), 32'd1);

    // All four channels period 1: round-robin 0,1,2,3 per tick
    do_reset();
    for (int c = 0; c < 4; c++) cfg(2'(c), 16'd1, 1'b0);
    evt_ready = 1'b1;
    tick_pulse();
    tick_pulse();
    chk("t2_count", 32'(evq.size()), 32'd8);
    ok = (evq.size() == 8);
    for (int i = 0; i < 8; i++) if (ok && evq[i] != 2'(i % 4)) ok = 1'b0;
    chk("t2_order", 32'(ok), 32'd1);
    ok = (evcyc.size() == 8);
    for (int i = 1; i < 8; i++) if (ok && i != 4 && (evcyc[i] - evcyc[i-1]) != 2) ok = 1'b0;
    chk("t2_spacing", 32'(ok), 32'd1);
    chk("t2_ovr", 32'(overrun), 32'd0);

    // Channel 2 period 2, consumer stalled: stable offer and overrun
    do_reset();
    cfg(2'd2, 16'd2, 1'b0);
    evt_ready = 1'b0;
    tick_pulse();
    chk("t3_v_tick1", 32'(evt_valid), 32'd0);
    tick_pulse();
    chk("t3_v_tick2", 32'(evt_valid), 32'd1);
    chk("t3_ch_tick2", 32'(evt_ch), 32'd2);
    chk("t3_ovr_tick2", 32'(overrun), 32'd0);
    repeat (2) tick_pulse();
    chk("t3_ovr_tick4", 32'(overrun), 32'h4);
    chk("t3_ch_tick4", 32'(evt_ch), 32'd2);
    repeat (2) tick_pulse();
    chk("t3_v_tick6", 32'(evt_valid), 32'd1);
    chk("t3_ch_tick6", 32'(evt_ch), 32'd2);
    cfg(2'd2, 16'd2, 1'b0);
    chk("t3_ovr_cfg", 32'(overrun), 32'd0);
    chk("t3_no_retract", 32'(evt_valid), 32'd1);
    evt_ready = 1'b1;
    step(1);
    evt_ready = 1'b0;
    chk("t3_accepted", 32'(evt_valid), 32'd0);
    chk("t3_evq", 32'(evq.size()), 32'd1);
    step(3);
    chk("t3_pend_cleared", 32'(evt_valid), 32'd0);

    // Accept coinciding with re-expiry of the same channel
    do_reset();
    cfg(2'd2, 16'd1, 1'b0);
    evt_ready = 1'b0;
    tick_pulse();
    chk("t4_v_offer", 32'(evt_valid), 32'd1);
    tick = 1'b1;
    evt_ready = 1'b1;
    step(1);
    evt_ready = 1'b0;
    chk("t4_v_drop", 32'(evt_valid), 32'd0);
    chk("t4_ovr_e0", 32'(overrun), 32'd0);
    step(1);
    chk("t4_v_again", 32'(evt_valid), 32'd1);
    chk("t4_ch_again", 32'(evt_ch), 32'd2);
    step(3);
    tick = 1'b0;
    step(45);
    chk("t4_ovr_end", 32'(overrun), 32'd0);
    chk("t4_evq", 32'(evq.size()), 32'd1);
    evt_ready = 1'b1;
    step(1);
    evt_ready = 1'b0;

    // Asynchronous reset while offering
    do_reset();
    cfg(2'd1, 16'd1, 1'b0);
    tick_pulse();
    tick_pulse();
    chk("t5_v_pre", 32'(evt_valid), 32'd1);
    chk("t5_ovr_pre", 32'(overrun), 32'h2);
    rst = 1'b0;
    #1;
    chk("t5_v_async", 32'(evt_valid), 32'd0);
    chk("t5_ovr_async", 32'(overrun), 32'd0);
    step(2);
    rst = 1'b1;
    step(1);
    evq.delete();
    evt_ready = 1'b1;
    repeat (10) tick_pulse();
    chk("t5_no_events", 32'(evq.size()), 32'd0);
    chk("t5_v_idle", 32'(evt_valid), 32'd0);

    // One-shot select
    do_reset();
    evt_ready = 1'b1;
    cfg(2'd1, 16'd4, 1'b1);
`ifdef SCHED_ONESHOT_EN
    repeat (3) tick_pulse();
    chk("t6_none3", 32'(evq.size()), 32'd0);
    tick_pulse();
    chk("t6_one", 32'(evq.size()), 32'd1);
    ok = (evq.size() == 1) && (evq[0] == 2'd1);
    chk("t6_ch", 32'(ok), 32'd1);
    repeat (20) tick_pulse();
    chk("t6_disarmed", 32'(evq.size()), 32'd1);
    cfg(2'd1, 16'd4, 1'b1);
    repeat (4) tick_pulse();
    chk("t6_rearm", 32'(evq.size()), 32'd2);
`else
    repeat (12) tick_pulse();
    chk("t6_periodic", 32'(evq.size()), 32'd3);
    ok = (evq.size() == 3);
    for (int i = 0; i < 3; i++) if (ok && evq[i] != 2'd1) ok = 1'b0;
    chk("t6_ch", 32'(ok), 32'd1);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/us_event_sched.md
Name: us_event_sched

Overview:
- Periodic event scheduler driven by the 1 MHz timebase tick (`stime`, 5-clk-wide high pulse every 50 clk).
- Holds NCH independent microsecond timers, each with a programmable period, and raises a pending flag per channel on expiry.
- Arbitrates pending channels round-robin onto a single valid/ready event port consumed by the control sequencer.

Parameters:
- NCH, 4, number of timer channels (2..8)
- PW, 16, period/counter width in microsecond ticks
- CW, 2, channel index width; must satisfy 2**CW >= NCH

Ports:
- clk  in  1  system clock, 50 MHz
- rst  in  1  asynchronous active-low reset
- tick  in  1  timebase tick; multi-cycle high pulse, rising edge counts
- cfg_we  in  1  configuration write strobe, one clk
- cfg_ch  in  CW  channel being configured
- cfg_period  in  PW  period in ticks; 0 = channel disabled
- cfg_oneshot  in  1  one-shot mode select; ignored unless SCHED_ONESHOT_EN
- evt_valid  out  1  event offered
- evt_ch  out  CW  channel of offered event
- evt_ready  in  1  consumer accepts event
- overrun  out  NCH  sticky per-channel overrun flags

Behaviour:
- Reset (rst=0, async): all counters, periods, pending, overrun and tick_d are 0; evt_valid=0; evt_ch=0; RR pointer=0.
- Tick detect: tick_rise = tick & ~tick_d, with tick_d registered. Exactly one count per `tick` pulse regardless of pulse width.
- Counter, per channel with period!=0:
  - On tick_rise, if cnt==period-1 then cnt<=0 and expire; else cnt<=cnt+1.
  - period=1 expires on every tick.
  - period=0 holds cnt at 0 and never expires.
- Pending: expire sets pend[ch].
  - If pend[ch] is already set and not being cleared this cycle, set overrun[ch]. The event is merged, not queued.
- Output FSM, states IDLE and OFFER:
  - IDLE: if any pend is set, choose the first set bit searching from rr_ptr upward with wrap. Register evt_ch, set evt_valid=1, go to OFFER.
  - OFFER: evt_valid and evt_ch are held stable until evt_ready=1.
  - On evt_valid&evt_ready: clear pend[evt_ch], set rr_ptr=evt_ch+1 (wrapping at NCH), evt_valid<=0, return to IDLE.
  - Minimum one idle clk between events.
- Latency: a tick rising edge is followed by evt_valid two clk later (tick_d, then pend, then offer) when the port is idle.
- Simultaneous events:
  - Accept and re-expiry of the same channel in one clk: pend stays 1, no overrun.
  - Several channels expiring on the same tick: all pend bits set and are served in RR order.
- Config write (cfg_we), for channel cfg_ch:
  - Loads period and sets cnt<=0.
  - Clears pend and overrun for that channel. This takes priority over a same-cycle expiry.
  - If that channel is currently offered, evt_valid stays asserted until accepted (no retraction). The pend clear still applies.
- cfg_ch >= NCH: write ignored.
- Counter and period arithmetic is unsigned PW-bit. cnt never exceeds period-1, so there is no wrap beyond the period.
- Reset mid-operation drops any offered event immediately (evt_valid=0 asynchronously).

Optional Feature:
- Macro SCHED_ONESHOT_EN.
- Defined:
  - Per-channel oneshot bit is loaded from cfg_oneshot.
  - On expiry of a oneshot channel, its period is cleared to 0, disabling it after a single event. A re-write is required to re-arm.
- Undefined:
  - cfg_oneshot is ignored; all channels are periodic; no oneshot storage is synthesized.

Decomposition:
- Shared package us_sched_pkg holds:
  - NCH/PW/CW defaults
  - Output FSM state encodings (S_IDLE=1'b0, S_OFFER=1'b1)
  - The tick rising-edge detect as a common constant convention
- One natural sub-module, us_sched_chan, instantiated NCH times. It contains the period register, counter, expire logic and optional oneshot bit.
- Arbiter, pend/overrun and output FSM live in the top level.

Test Plan:
- Tick generator (50-clk period, 5 high): channel 0 period=3, evt_ready tied 1 -> exactly one evt_ch=0 event per 3 tick pulses, evt_valid 2 clk after the 3rd rising edge, never more than 1 event per tick.
- Channels 0..3 all period=1, evt_ready=1 -> events ordered 0,1,2,3,0,...; each evt_valid one clk wide with one idle clk between; no overrun.
- Channel 2 period=2, evt_ready held 0 for 6 ticks -> evt_valid=1 with evt_ch=2 stable throughout; overrun[2]=1 after the 2nd expiry. Cfg write to ch 2 -> overrun[2]=0.
- Accept coinciding with same-channel expiry -> pend[2] remains set, a new event follows, overrun[2] stays 0.
- Assert rst=0 while evt_valid=1 -> evt_valid=0 and overrun=0 immediately. After release, period=0 on all channels gives no events across 10 ticks.
- SCHED_ONESHOT_EN: ch1 period=4, oneshot=1 -> a single event after 4 ticks, none over the next 20. Re-write -> one more event.
